// File: rtl/my_pkg.sv
// Shared types and constants for the write-back arbiter.
//   arb_state_e : arbiter FSM states (run, one-cycle flush, terminal error)
//   TAG_W       : width of the in-order instruction tag
package my_pkg;

  localparam int unsigned TAG_W = 4;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1,
    StError = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_prio_enc.sv
// Fixed-priority encoder: lowest set bit of match wins.
//   match_i : per-requester match vector
//   grant_o : one-hot grant (lowest-index match), zero when no match
//   idx_o   : binary index of the granted requester (0 when no match)
//   multi_o : two or more bits of match_i are set
module wb_prio_enc #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] match_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            multi_o
);

  always_comb begin
    // Two's-complement trick isolates the lowest set bit.
    grant_o = match_i & (~match_i + NREQ'(1));
    // Clearing the lowest set bit leaves something only if >= 2 bits were set.
    multi_o = |(match_i & (match_i - NREQ'(1)));
    idx_o   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (match_i[k]) idx_o = IdxW'(k);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// In-order write-back arbiter: several execution units share one register-bank
// write port; results retire strictly in tag order tracked by exp_tag.
//   clk, reset (async, active-low)
//   req_valid/req_tag/req_we/req_rd/req_data : per-requester result
//   req_ready     : combinational grant, lowest-index requester whose tag matches
//   flush/flush_tag : realign expected tag (one-cycle FLUSH bubble)
//   wr_en/wr_addr/wr_data : registered register-bank write
//   release_mask  : registered one-hot lock release, bit r <=> register r
//                   ("release" is a reserved word, hence the suffix)
//   retire_tag/retire_valid : registered retirement report
//   dup_err       : sticky, two requesters carried the expected tag together
//   err           : sticky, watchdog expired (exit by reset only)
module wb_arbiter
  import my_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][TAG_W-1:0]  req_tag,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ-1:0][4:0]        req_rd,
  input  logic [NREQ-1:0][31:0]       req_data,
  output logic [NREQ-1:0]             req_ready,
  input  logic                        flush,
  input  logic [TAG_W-1:0]            flush_tag,
  output logic                        wr_en,
  output logic [4:0]                  wr_addr,
  output logic [31:0]                 wr_data,
  output logic [31:1]                 release_mask,
  output logic [TAG_W-1:0]            retire_tag,
  output logic                        retire_valid,
  output logic                        dup_err,
  output logic                        err
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [TAG_W-1:0]  exp_tag_q, exp_tag_d;
  logic [WdW-1:0]    wdog_q, wdog_d, wdog_inc;
  logic              dup_err_q, dup_err_d;

  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:1]       release_q, release_d;
  logic [TAG_W-1:0]  retire_tag_q, retire_tag_d;
  logic              retire_valid_q, retire_valid_d;

  logic              arb_en;
  logic [NREQ-1:0]   match;
  logic [NREQ-1:0]   grant;
  logic [IdxW-1:0]   gnt_idx;
  logic              multi;
  logic              xfer;
  logic [4:0]        sel_rd;
  logic              sel_we;
  logic [31:0]       sel_data;

  // Arbitration only happens in RUN on a cycle without flush; gating the match
  // vector also keeps dup detection and the grant consistent with each other.
  always_comb begin
    arb_en = (state_q == StRun) && !flush;
    match  = '0;
    for (int k = 0; k < NREQ; k++) begin
      match[k] = arb_en && req_valid[k] && (req_tag[k] == exp_tag_q);
    end
  end

  wb_prio_enc #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_prio_enc (
    .match_i (match),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .multi_o (multi)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_rd    = req_rd[gnt_idx];
  assign sel_we    = req_we[gnt_idx];
  assign sel_data  = req_data[gnt_idx];
  assign wdog_inc  = wdog_q + WdW'(1);

  // FSM, expected tag and watchdog.
  always_comb begin
    state_d   = state_q;
    exp_tag_d = exp_tag_q;
    wdog_d    = wdog_q;
    dup_err_d = dup_err_q | multi;
    unique case (state_q)
      StRun: begin
        if (flush) begin
          exp_tag_d = flush_tag;
          wdog_d    = '0;
          state_d   = StFlush;
        end else if (xfer) begin
          exp_tag_d = exp_tag_q + TAG_W'(1);
          wdog_d    = '0;
        end else if (req_valid == '0) begin
          wdog_d = '0;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WdW'(TIMEOUT)) state_d = StError;
        end
      end
      StFlush: begin
        wdog_d = '0;
        if (flush) exp_tag_d = flush_tag;
        else       state_d   = StRun;
      end
      StError: begin
        // Terminal until reset.
      end
      default: state_d = StError;
    endcase
  end

  // Write-port and retirement outputs, one cycle behind the transfer.
  always_comb begin
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    release_d      = '0;
    retire_tag_d   = retire_tag_q;
    retire_valid_d = 1'b0;
    if (xfer) begin
      wr_en_d        = sel_we && (sel_rd != 5'd0);
      wr_addr_d      = sel_rd;
      wr_data_d      = sel_data;
      retire_tag_d   = exp_tag_q;
      retire_valid_d = 1'b1;
      // Shift then drop bit 0 so register r lands on release bit r.
      release_d      = wr_en_d ? 31'((32'(1) << sel_rd) >> 1) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StRun;
      exp_tag_q      <= '0;
      wdog_q         <= '0;
      dup_err_q      <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      release_q      <= '0;
      retire_tag_q   <= '0;
      retire_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      exp_tag_q      <= exp_tag_d;
      wdog_q         <= wdog_d;
      dup_err_q      <= dup_err_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      release_q      <= release_d;
      retire_tag_q   <= retire_tag_d;
      retire_valid_q <= retire_valid_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign release_mask = release_q;
  assign retire_tag   = retire_tag_q;
  assign retire_valid = retire_valid_q;
  assign dup_err      = dup_err_q;
  assign err          = (state_q == StError);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NREQ=4, TIMEOUT=15). Inputs change 1ns after
// the rising edge; outputs are checked at that point or 1ns after driving.
module tb_wb_arbiter;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0][3:0]  req_tag;
  logic [3:0]       req_we;
  logic [3:0][4:0]  req_rd;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic             flush;
  logic [3:0]       flush_tag;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [31:1]      release_mask;
  logic [3:0]       retire_tag;
  logic             retire_valid;
  logic             dup_err;
  logic             err;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(
    .NREQ    (4),
    .TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_we       (req_we),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .flush        (flush),
    .flush_tag    (flush_tag),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .release_mask (release_mask),
    .retire_tag   (retire_tag),
    .retire_valid (retire_valid),
    .dup_err      (dup_err),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_tag   = '0;
    req_we    = '0;
    req_rd    = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int k, input logic [3:0] tag, input logic we,
                         input logic [4:0] rd, input logic [31:0] data);
    req_valid[k] = 1'b1;
    req_tag[k]   = tag;
    req_we[k]    = we;
    req_rd[k]    = rd;
    req_data[k]  = data;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [31:1] rel_bit(input int r);
    logic [31:1] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    flush_tag = '0;
    clear_req();
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_release", release_mask, 0);
    chk("rst_err", err, 0);
    chk("rst_dup_err", dup_err, 0);
    chk("rst_wr_addr", wr_addr, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Single transfer from requester 2.
    set_req(2, 4'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("s1_ready", req_ready, 4'b0100);
    tick();
    clear_req();
    chk("s1_wr_en", wr_en, 1);
    chk("s1_wr_addr", wr_addr, 5);
    chk("s1_wr_data", wr_data, 32'hDEAD_BEEF);
    chk("s1_release", release_mask, rel_bit(5));
    chk("s1_retire_tag", retire_tag, 0);
    chk("s1_retire_valid", retire_valid, 1);
    tick();
    chk("s1_idle_wr_en", wr_en, 0);
    chk("s1_idle_rv", retire_valid, 0);
    chk("s1_idle_release", release_mask, 0);
    chk("s1_hold_addr", wr_addr, 5);
    chk("s1_hold_data", wr_data, 32'hDEAD_BEEF);

    // Out-of-order arrival: tag 0 on requester 1 retires before tag 1 on requester 0.
    do_reset();
    set_req(0, 4'd1, 1'b1, 5'd1, 32'h11);
    set_req(1, 4'd0, 1'b1, 5'd2, 32'h22);
    #1;
    chk("s2_ready_a", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    chk("s2_tag_a", retire_tag, 0);
    chk("s2_addr_a", wr_addr, 2);
    #1;
    chk("s2_ready_b", req_ready, 4'b0001);
    tick();
    clear_req();
    chk("s2_tag_b", retire_tag, 1);
    chk("s2_addr_b", wr_addr, 1);
    chk("s2_data_b", wr_data, 32'h11);
    chk("s2_release_b", release_mask, rel_bit(1));

    // 17 in-order transfers: tag wraps 15 -> 0.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      clear_req();
      set_req(i % 4, 4'(i % 16), 1'b1, 5'(i + 1), 32'(i));
      #1;
      chk("s3_ready", req_ready, 64'(1) << (i % 4));
      tick();
      chk("s3_retire_tag", retire_tag, 64'(i % 16));
      chk("s3_wr_addr", wr_addr, 64'(i + 1));
      chk("s3_release", release_mask, rel_bit(i + 1));
    end
    clear_req();

    // x0 destination and we=0 still retire but never write.
    set_req(3, 4'd1, 1'b1, 5'd0, 32'hAA);
    #1;
    chk("s4_ready_x0", req_ready, 4'b1000);
    tick();
    clear_req();
    chk("s4_x0_wr_en", wr_en, 0);
    chk("s4_x0_rv", retire_valid, 1);
    chk("s4_x0_tag", retire_tag, 1);
    chk("s4_x0_release", release_mask, 0);
    set_req(0, 4'd2, 1'b0, 5'd7, 32'hBB);
    #1;
    chk("s4_ready_nowe", req_ready, 4'b0001);
    tick();
    clear_req();
    chk("s4_nowe_wr_en", wr_en, 0);
    chk("s4_nowe_rv", retire_valid, 1);
    chk("s4_nowe_addr", wr_addr, 7);
    chk("s4_nowe_release", release_mask, 0);

    // Flush to 9 while tags 3 (currently expected) and 9 are both waiting.
    do_reset();
    flush     = 1'b1;
    flush_tag = 4'd3;
    tick();
    flush = 1'b0;
    tick();
    set_req(0, 4'd3, 1'b1, 5'd3, 32'h33);
    set_req(1, 4'd9, 1'b1, 5'd9, 32'h99);
    #1;
    chk("s5_pre_ready", req_ready, 4'b0001);
    flush     = 1'b1;
    flush_tag = 4'd9;
    #1;
    chk("s5_flush_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    chk("s5_flush_rv", retire_valid, 0);
    #1;
    chk("s5_fstate_ready", req_ready, 0);
    tick();
    chk("s5_fstate_rv", retire_valid, 0);
    #1;
    chk("s5_run_ready", req_ready, 4'b0010);
    tick();
    clear_req();
    chk("s5_retire_tag", retire_tag, 9);
    chk("s5_wr_data", wr_data, 32'h99);

    // Duplicate expected tag.
    do_reset();
    set_req(0, 4'd0, 1'b1, 5'd10, 32'h100);
    set_req(2, 4'd0, 1'b1, 5'd12, 32'h300);
    #1;
    chk("s6_ready", req_ready, 4'b0001);
    tick();
    clear_req();
    chk("s6_dup_err", dup_err, 1);
    chk("s6_wr_addr", wr_addr, 10);
    tick();
    chk("s6_dup_sticky", dup_err, 1);

    // Watchdog: tag 7 while expecting 0, held.
    do_reset();
    chk("s7_dup_cleared", dup_err, 0);
    set_req(1, 4'd7, 1'b1, 5'd4, 32'h77);
    for (int c = 1; c <= 14; c++) begin
      tick();
    end
    chk("s7_err_before", err, 0);
    tick();
    chk("s7_err_after", err, 1);
    set_req(0, 4'd0, 1'b1, 5'd6, 32'h66);
    #1;
    chk("s7_ready_error", req_ready, 0);
    flush     = 1'b1;
    flush_tag = 4'd7;
    tick();
    flush = 1'b0;
    chk("s7_err_after_flush", err, 1);
    #1;
    chk("s7_ready_after_flush", req_ready, 0);
    tick();
    chk("s7_no_retire", retire_valid, 0);
    clear_req();
    do_reset();
    chk("s7_err_reset", err, 0);

    // Reset held across the edge where a transfer would have happened.
    set_req(0, 4'd0, 1'b1, 5'd4, 32'h44);
    #1;
    chk("s8_ready", req_ready, 4'b0001);
    reset = 1'b0;
    tick();
    clear_req();
    reset = 1'b1;
    chk("s8_wr_en_reset", wr_en, 0);
    tick();
    chk("s8_wr_en_after", wr_en, 0);
    chk("s8_rv_after", retire_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
